// File: rtl/reg_bank_reader.sv
// Purpose : register bank, one write port, two independent registered read
//           ports, plus a sequenced clear engine that zeroes one entry per cycle.
// Latency : 1 cycle from read request to oRdDataX/oRdValidX; clear takes DEPTH cycles.
// Backpr. : none - every request is answered; writes are dropped while oBusy=1.
// Ports   : CLK/RST (async, active-high); iWrEn/iWrAddr/iWrData write port;
//           iRdReqX/iRdAddrX -> oRdDataX/oRdValidX read ports A and B;
//           iClear starts the clear sequence, oBusy flags it in progress.
module reg_bank_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iRdReqA,
  input  logic [ADDR_W-1:0] iRdAddrA,
  output logic [DATA_W-1:0] oRdDataA,
  output logic              oRdValidA,
  input  logic              iRdReqB,
  input  logic [ADDR_W-1:0] iRdAddrB,
  output logic [DATA_W-1:0] oRdDataB,
  output logic              oRdValidB,
  input  logic              iClear,
  output logic              oBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Single effective write port into the bank: either the user write
  // (only in IDLE, and lost to a simultaneous iClear) or the clear engine.
  logic              wr_accept;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] rd_val_a;
  logic [DATA_W-1:0] rd_val_b;

  always_comb begin
    wr_accept  = iWrEn && (state == IDLE) && !iClear;
    bank_we    = 1'b0;
    bank_waddr = iWrAddr;
    bank_wdata = iWrData;
    if (state == CLEAR) begin
      bank_we    = 1'b1;
      bank_waddr = cnt;
      bank_wdata = '0;
    end else if (wr_accept) begin
      bank_we = 1'b1;
    end
  end

  // Write-first bypass: a read colliding with this edge's write (user or
  // clear) returns the value being written.
  always_comb begin
    rd_val_a = mem[iRdAddrA];
    rd_val_b = mem[iRdAddrB];
    if (bank_we && (bank_waddr == iRdAddrA)) rd_val_a = bank_wdata;
    if (bank_we && (bank_waddr == iRdAddrB)) rd_val_b = bank_wdata;
  end

  // Clear sequencer. oBusy is registered alongside the state so it is high
  // exactly for the DEPTH cycles the FSM spends in CLEAR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      oBusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iClear) begin
            state <= CLEAR;
            cnt   <= '0;
            oBusy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + ADDR_W'(1);  // wraps to 0 after the last entry
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bank_we) begin
      mem[bank_waddr] <= bank_wdata;
    end
  end

  // Read responses: data only updates on a request, so it holds otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oRdDataA  <= '0;
      oRdValidA <= 1'b0;
      oRdDataB  <= '0;
      oRdValidB <= 1'b0;
    end else begin
      oRdValidA <= iRdReqA;
      oRdValidB <= iRdReqB;
      if (iRdReqA) oRdDataA <= rd_val_a;
      if (iRdReqB) oRdDataB <= rd_val_b;
    end
  end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader: table of directed vectors for the
// single-cycle behaviour, hand-written sequences for clear and async reset.
module tb_reg_bank_reader;

  logic       CLK;
  logic       RST;
  logic       iWrEn;
  logic [2:0] iWrAddr;
  logic [7:0] iWrData;
  logic       iRdReqA;
  logic [2:0] iRdAddrA;
  logic [7:0] oRdDataA;
  logic       oRdValidA;
  logic       iRdReqB;
  logic [2:0] iRdAddrB;
  logic [7:0] oRdDataB;
  logic       oRdValidB;
  logic       iClear;
  logic       oBusy;

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank_reader #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iWrEn    (iWrEn),
    .iWrAddr  (iWrAddr),
    .iWrData  (iWrData),
    .iRdReqA  (iRdReqA),
    .iRdAddrA (iRdAddrA),
    .oRdDataA (oRdDataA),
    .oRdValidA(oRdValidA),
    .iRdReqB  (iRdReqB),
    .iRdAddrB (iRdAddrB),
    .oRdDataB (oRdDataB),
    .oRdValidB(oRdValidB),
    .iClear   (iClear),
    .oBusy    (oBusy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       req_a;
    logic [2:0] addr_a;
    logic       req_b;
    logic [2:0] addr_b;
    logic       exp_vld_a;
    logic [7:0] exp_dat_a;
    logic       exp_vld_b;
    logic [7:0] exp_dat_b;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(int we, int wa, int wd, int ra, int aa, int rb, int ab,
                              int va, int da, int vb, int db);
    vec_t v;
    v.wr_en     = 1'(we);
    v.wr_addr   = 3'(wa);
    v.wr_data   = 8'(wd);
    v.req_a     = 1'(ra);
    v.addr_a    = 3'(aa);
    v.req_b     = 1'(rb);
    v.addr_b    = 3'(ab);
    v.exp_vld_a = 1'(va);
    v.exp_dat_a = 8'(da);
    v.exp_vld_b = 1'(vb);
    v.exp_dat_b = 8'(db);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iWrEn = 1'b0; iWrAddr = '0; iWrData = '0;
    iRdReqA = 1'b0; iRdAddrA = '0;
    iRdReqB = 1'b0; iRdAddrB = '0;
    iClear = 1'b0;
  endtask

  task automatic write(input int a, input int d);
    iWrEn = 1'b1; iWrAddr = 3'(a); iWrData = 8'(d);
    step();
    iWrEn = 1'b0;
  endtask

  task automatic read_a(input string name, input int a, input int exp);
    iRdReqA = 1'b1; iRdAddrA = 3'(a);
    step();
    iRdReqA = 1'b0;
    chk({name, "_vld"}, int'(oRdValidA), 1);
    chk({name, "_dat"}, int'(oRdDataA), exp);
  endtask

  task automatic fill_bank();
    for (int i = 0; i < 8; i++) write(i, 8'h11 * (i + 1));
  endtask

  initial begin
    int busy_cycles;

    idle_inputs();
    RST = 1'b1;

    // Vectors: reads of all addresses after reset, write then read, same-edge
    // bypass on both ports, data hold, and back-to-back reads of 0..3.
    vecs[0]  = mk(0, 0, 8'h00, 1, 0, 1, 7, 1, 8'h00, 1, 8'h00);
    vecs[1]  = mk(0, 0, 8'h00, 1, 1, 1, 6, 1, 8'h00, 1, 8'h00);
    vecs[2]  = mk(0, 0, 8'h00, 1, 2, 1, 5, 1, 8'h00, 1, 8'h00);
    vecs[3]  = mk(0, 0, 8'h00, 1, 3, 1, 4, 1, 8'h00, 1, 8'h00);
    vecs[4]  = mk(1, 3, 8'h5A, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00);
    vecs[5]  = mk(0, 0, 8'h00, 1, 3, 0, 0, 1, 8'h5A, 0, 8'h00);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0, 8'h00);
    vecs[7]  = mk(1, 5, 8'hC3, 1, 5, 1, 5, 1, 8'hC3, 1, 8'hC3);
    vecs[8]  = mk(0, 0, 8'h00, 1, 5, 0, 0, 1, 8'hC3, 0, 8'hC3);
    vecs[9]  = mk(1, 0, 8'h01, 0, 0, 0, 0, 0, 8'hC3, 0, 8'hC3);
    vecs[10] = mk(1, 1, 8'h02, 0, 0, 0, 0, 0, 8'hC3, 0, 8'hC3);
    vecs[11] = mk(1, 2, 8'h03, 0, 0, 0, 0, 0, 8'hC3, 0, 8'hC3);
    vecs[12] = mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h01, 0, 8'hC3);
    vecs[13] = mk(0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h02, 0, 8'hC3);
    vecs[14] = mk(0, 0, 8'h00, 1, 2, 0, 0, 1, 8'h03, 0, 8'hC3);
    vecs[15] = mk(0, 0, 8'h00, 1, 3, 0, 0, 1, 8'h5A, 0, 8'hC3);
    vecs[16] = mk(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0, 8'hC3);

    // Reset state
    #12;
    chk("rst_dat_a", int'(oRdDataA), 0);
    chk("rst_vld_a", int'(oRdValidA), 0);
    chk("rst_dat_b", int'(oRdDataB), 0);
    chk("rst_vld_b", int'(oRdValidB), 0);
    chk("rst_busy",  int'(oBusy), 0);
    @(negedge CLK);
    RST = 1'b0;
    step();

    for (int i = 0; i < 17; i++) begin
      iWrEn = vecs[i].wr_en; iWrAddr = vecs[i].wr_addr; iWrData = vecs[i].wr_data;
      iRdReqA = vecs[i].req_a; iRdAddrA = vecs[i].addr_a;
      iRdReqB = vecs[i].req_b; iRdAddrB = vecs[i].addr_b;
      step();
      chk($sformatf("v%0d_vld_a", i), int'(oRdValidA), int'(vecs[i].exp_vld_a));
      chk($sformatf("v%0d_dat_a", i), int'(oRdDataA),  int'(vecs[i].exp_dat_a));
      chk($sformatf("v%0d_vld_b", i), int'(oRdValidB), int'(vecs[i].exp_vld_b));
      chk($sformatf("v%0d_dat_b", i), int'(oRdDataB),  int'(vecs[i].exp_dat_b));
      chk($sformatf("v%0d_busy", i),  int'(oBusy), 0);
    end
    idle_inputs();

    // Sequenced clear: write on the iClear edge is dropped, write during busy
    // is dropped, reads during clear see old data or 0 for the entry being cleared.
    fill_bank();
    iClear = 1'b1; iWrEn = 1'b1; iWrAddr = 3'd2; iWrData = 8'hFF;
    step();                                  // E0: enter CLEAR
    chk("clr_e0_busy", int'(oBusy), 1);
    iClear = 1'b0; iWrEn = 1'b1; iWrAddr = 3'd6; iWrData = 8'hEE;
    iRdReqA = 1'b1; iRdAddrA = 3'd2;
    iRdReqB = 1'b1; iRdAddrB = 3'd0;
    step();                                  // E1: clears entry 0
    chk("clr_e1_busy", int'(oBusy), 1);
    chk("clr_drop_on_clear", int'(oRdDataA), 8'h33);
    chk("clr_bypass_vld_b", int'(oRdValidB), 1);
    chk("clr_bypass_zero_b", int'(oRdDataB), 8'h00);
    iWrEn = 1'b0; iRdAddrA = 3'd6; iRdReqB = 1'b0;
    step();                                  // E2
    iRdReqA = 1'b0;
    chk("clr_e2_busy", int'(oBusy), 1);
    chk("clr_drop_busy_wr", int'(oRdDataA), 8'h77);
    busy_cycles = 3;
    iClear = 1'b1;                           // must be ignored while clearing
    for (int n = 0; n < 20; n++) begin
      step();
      iClear = 1'b0;
      if (!oBusy) break;
      busy_cycles++;
    end
    chk("clr_busy_cycles", busy_cycles, 8);
    for (int a = 0; a < 8; a++) read_a($sformatf("clr_rd%0d", a), a, 0);

    // Asynchronous reset part-way through a clear (cnt = 4).
    fill_bank();
    iClear = 1'b1;
    step();                                  // E0
    iClear = 1'b0;
    step(); step(); step();                  // E1..E3 clear entries 0..2
    iRdReqA = 1'b1; iRdAddrA = 3'd7;
    step();                                  // E4: cnt becomes 4
    iRdReqA = 1'b0;
    chk("pre_rst_dat_a", int'(oRdDataA), 8'h88);
    chk("pre_rst_busy", int'(oBusy), 1);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_dat_a", int'(oRdDataA), 0);
    chk("arst_vld_a", int'(oRdValidA), 0);
    chk("arst_busy", int'(oBusy), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    step();
    chk("post_rst_busy", int'(oBusy), 0);
    for (int a = 0; a < 8; a++) read_a($sformatf("post_rst_rd%0d", a), a, 0);
    chk("post_rst_busy2", int'(oBusy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
